// File: rtl/key_motion_ctrl_pkg.sv
// Shared types and constants for the keyboard-driven motion controller.
// Direction encoding is also exported on the dir debug output.
package key_motion_pkg;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  // USB HID usage codes of the keys the controller reacts to
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int STEP_W = 10;

endpackage

// File: rtl/key_motion_ctrl_if.sv
// Bundle of keyboard/frame inputs and per-frame motion outputs.
// master = the side feeding keys and vsync, slave = the controller.
interface key_motion_ctrl_if;
  logic [15:0] keycode;
  logic        frame_clk;
  logic [9:0]  step_x;
  logic [9:0]  step_y;
  logic        frame_tick;
  logic [2:0]  dir;

  modport master (
    output keycode, frame_clk,
    input  step_x, step_y, frame_tick, dir
  );

  modport slave (
    input  keycode, frame_clk,
    output step_x, step_y, frame_tick, dir
  );
endinterface

// File: rtl/key_motion_ctrl_decode.sv
// Maps one 8-bit HID usage code to a motion direction.
// Codes that are not motion keys raise 'none' so the caller can fall back.
module key_decode
  import key_motion_pkg::*;
(
  input  logic [7:0] code,
  output dir_t       dir,
  output logic       none
);

  // Pure lookup; space maps to STOP, everything unknown is flagged as none
  always_comb begin
    dir  = STOP;
    none = 1'b0;
    unique case (code)
      KEY_W:     dir = UP;
      KEY_S:     dir = DOWN;
      KEY_A:     dir = LEFT;
      KEY_D:     dir = RIGHT;
      KEY_SPACE: dir = STOP;
      default:   none = 1'b1;
    endcase
  end

endmodule

// File: rtl/key_motion_ctrl.sv
// Per-frame motion controller: samples the pressed key once per vsync
// rising edge, tracks the motion direction and doubles the step after the
// same direction has been held for BOOST_FRAMES consecutive frames.
module key_motion_ctrl
  import key_motion_pkg::*;
#(
  parameter int STEP         = 1,
  parameter int BOOST_FRAMES = 30
) (
  input logic               Clk,
  input logic               Reset,
  key_motion_ctrl_if.slave  bus
);

  localparam int                CNT_W     = $clog2(BOOST_FRAMES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(BOOST_FRAMES);
  localparam logic [STEP_W-1:0] MAG_BASE  = STEP_W'(STEP);
  localparam logic [STEP_W-1:0] MAG_BOOST = STEP_W'(2 * STEP);

  dir_t              dir0, dir1, key_dir;
  logic              none0, none1, key_none;
  logic              sync1, sync2, sync3;
  logic              frame_event;
  dir_t              state, next_state;
  logic [CNT_W-1:0]  hold_cnt, next_cnt;
  logic [STEP_W-1:0] mag, next_x, next_y;
  logic [STEP_W-1:0] step_x_q, step_y_q;
  logic              tick_q;

  key_decode u_dec0 (.code(bus.keycode[7:0]),  .dir(dir0), .none(none0));
  key_decode u_dec1 (.code(bus.keycode[15:8]), .dir(dir1), .none(none1));

  // Slot 0 has priority whenever it holds a recognised key
  assign key_none    = none0 & none1;
  assign key_dir     = none0 ? dir1 : dir0;
  assign frame_event = sync2 & ~sync3;

  // Two-flop synchroniser for vsync plus a third stage for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.frame_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Next direction, hold count and the step vector they imply
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    if (!key_none) begin
      if (key_dir == STOP) begin
        next_state = STOP;
      end else if (key_dir == state) begin
        next_cnt = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + 1'b1;
      end else begin
        next_state = key_dir;
      end
    end
    mag    = (next_cnt == CNT_MAX) ? MAG_BOOST : MAG_BASE;
    next_x = '0;
    next_y = '0;
    unique case (next_state)
      UP:      next_y = -mag;
      DOWN:    next_y = mag;
      LEFT:    next_x = -mag;
      RIGHT:   next_x = mag;
      default: ;
    endcase
  end

  // Direction FSM and registered outputs, advanced only on a frame event
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= STOP;
      hold_cnt <= '0;
      step_x_q <= '0;
      step_y_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= frame_event;
      if (frame_event) begin
        state    <= next_state;
        hold_cnt <= next_cnt;
        step_x_q <= next_x;
        step_y_q <= next_y;
      end
    end
  end

  assign bus.step_x     = step_x_q;
  assign bus.step_y     = step_y_q;
  assign bus.frame_tick = tick_q;
  assign bus.dir        = state;

endmodule

// File: tb/tb_key_motion_ctrl.sv
// Self-checking bench for key_motion_ctrl: directed scenarios plus a
// randomized key sequence compared against a frame-level reference model.
module tb_key_motion_ctrl;

  localparam int BOOST = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: direction as 0..4 and count of repeat frames
  int   m_dir = 0;
  int   m_hold = 0;

  always #10 clk = ~clk;

  key_motion_ctrl_if bus ();

  key_motion_ctrl #(.STEP(1), .BOOST_FRAMES(BOOST)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  // Hard stop in case some wait never returns
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int decode_code(input logic [7:0] c);
    case (c)
      8'h1A:   return 1;
      8'h16:   return 2;
      8'h04:   return 3;
      8'h07:   return 4;
      8'h2C:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic void model_reset();
    m_dir  = 0;
    m_hold = 0;
  endfunction

  function automatic void model_frame(input logic [15:0] k);
    int d0, d1, d;
    d0 = decode_code(k[7:0]);
    d1 = decode_code(k[15:8]);
    d  = (d0 >= 0) ? d0 : d1;
    if (d < 0) begin
      m_hold = 0;
    end else if (d == 0) begin
      m_dir  = 0;
      m_hold = 0;
    end else if (d == m_dir) begin
      m_hold = (m_hold + 1 > BOOST) ? BOOST : m_hold + 1;
    end else begin
      m_dir  = d;
      m_hold = 0;
    end
  endfunction

  function automatic int exp_x();
    int mag;
    mag = (m_hold == BOOST) ? 2 : 1;
    return (m_dir == 3) ? -mag : (m_dir == 4) ? mag : 0;
  endfunction

  function automatic int exp_y();
    int mag;
    mag = (m_hold == BOOST) ? 2 : 1;
    return (m_dir == 1) ? -mag : (m_dir == 2) ? mag : 0;
  endfunction

  // One vsync pulse with key k; reports tick count and the cycle it landed on
  task automatic run_frame(input logic [15:0] k, output int ticks, output int pos);
    @(negedge clk);
    bus.keycode   = k;
    bus.frame_clk = 1'b1;
    ticks = 0;
    pos   = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_tick === 1'b1) begin
        ticks++;
        pos = i;
      end
      if (i == 2) bus.frame_clk = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.keycode   = 16'h0000;
    bus.frame_clk = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.step_x !== 10'd0) begin errors++; $display("[TB] FAIL reset_step_x got %h want 000", bus.step_x); end
    checks++; if (bus.step_y !== 10'd0) begin errors++; $display("[TB] FAIL reset_step_y got %h want 000", bus.step_y); end
    checks++; if (bus.dir !== 3'd0) begin errors++; $display("[TB] FAIL reset_dir got %0d want 0", bus.dir); end
    checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b want 0", bus.frame_tick); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single_frame();
    int ticks, pos;
    run_frame(16'h001A, ticks, pos);
    model_frame(16'h001A);
    checks++; if (ticks !== 1) begin errors++; $display("[TB] FAIL first_tick_count got %0d want 1", ticks); end
    checks++; if (pos !== 3) begin errors++; $display("[TB] FAIL first_latency got %0d want 3", pos); end
    checks++; if (bus.step_y !== 10'h3FF) begin errors++; $display("[TB] FAIL first_step_y got %h want 3ff", bus.step_y); end
    checks++; if (bus.step_x !== 10'd0) begin errors++; $display("[TB] FAIL first_step_x got %h want 000", bus.step_x); end
    checks++; if (bus.dir !== 3'd1) begin errors++; $display("[TB] FAIL first_dir got %0d want 1", bus.dir); end
  endtask

  task automatic test_boost();
    int ticks, pos;
    for (int f = 1; f <= 31; f++) begin
      run_frame(16'h0007, ticks, pos);
      model_frame(16'h0007);
      checks++;
      if (bus.step_x !== 10'(exp_x()) || ticks !== 1) begin
        errors++;
        $display("[TB] FAIL boost_frame%0d got x=%0d ticks=%0d want x=%0d ticks=1", f, $signed(bus.step_x), ticks, exp_x());
      end
      if (f == 30) begin
        checks++; if (bus.step_x !== 10'd1) begin errors++; $display("[TB] FAIL boost_f30 got %0d want 1", $signed(bus.step_x)); end
      end
      if (f == 31) begin
        checks++; if (bus.step_x !== 10'd2) begin errors++; $display("[TB] FAIL boost_f31 got %0d want 2", $signed(bus.step_x)); end
      end
    end
    run_frame(16'h0000, ticks, pos);
    model_frame(16'h0000);
    checks++; if (bus.step_x !== 10'd1) begin errors++; $display("[TB] FAIL boost_release got %0d want 1", $signed(bus.step_x)); end
    checks++; if (bus.dir !== 3'd4) begin errors++; $display("[TB] FAIL boost_release_dir got %0d want 4", bus.dir); end
  endtask

  task automatic test_priority();
    int ticks, pos;
    run_frame(16'h0416, ticks, pos);
    model_frame(16'h0416);
    checks++; if (bus.step_y !== 10'd1 || bus.step_x !== 10'd0) begin errors++; $display("[TB] FAIL prio_slot0 got x=%h y=%h want x=000 y=001", bus.step_x, bus.step_y); end
    checks++; if (bus.dir !== 3'd2) begin errors++; $display("[TB] FAIL prio_slot0_dir got %0d want 2", bus.dir); end
    run_frame(16'h0400, ticks, pos);
    model_frame(16'h0400);
    checks++; if (bus.step_x !== 10'h3FF || bus.step_y !== 10'd0) begin errors++; $display("[TB] FAIL prio_slot1 got x=%h y=%h want x=3ff y=000", bus.step_x, bus.step_y); end
    checks++; if (bus.dir !== 3'd3) begin errors++; $display("[TB] FAIL prio_slot1_dir got %0d want 3", bus.dir); end
  endtask

  task automatic test_transient_key();
    int ticks, pos, stray;
    run_frame(16'h0007, ticks, pos);
    model_frame(16'h0007);
    stray = 0;
    @(negedge clk);
    bus.keycode = 16'h002C;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.frame_tick === 1'b1) stray++;
    end
    @(negedge clk);
    bus.keycode = 16'h0000;
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL transient_tick got %0d want 0", stray); end
    checks++; if (bus.step_x !== 10'd1) begin errors++; $display("[TB] FAIL transient_hold got %0d want 1", $signed(bus.step_x)); end
    run_frame(16'h0000, ticks, pos);
    model_frame(16'h0000);
    checks++; if (bus.step_x !== 10'd1 || bus.dir !== 3'd4) begin errors++; $display("[TB] FAIL transient_next got x=%0d dir=%0d want x=1 dir=4", $signed(bus.step_x), bus.dir); end
  endtask

  task automatic test_reset_mid_boost();
    int ticks, pos, stray;
    for (int f = 1; f <= 31; f++) begin
      run_frame(16'h001A, ticks, pos);
      model_frame(16'h001A);
    end
    checks++; if (bus.step_y !== 10'h3FE) begin errors++; $display("[TB] FAIL midboost_pre got %0d want -2", $signed(bus.step_y)); end
    // Event becomes live after the second edge; reset lands on the update edge
    @(negedge clk);
    bus.frame_clk = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.frame_clk = 1'b0;
    stray = 0;
    @(posedge clk); #1;
    if (bus.frame_tick === 1'b1) stray++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.frame_tick === 1'b1) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL midboost_tick got %0d want 0", stray); end
    checks++; if (bus.step_x !== 10'd0 || bus.step_y !== 10'd0 || bus.dir !== 3'd0) begin errors++; $display("[TB] FAIL midboost_clear got x=%h y=%h dir=%0d want 0 0 0", bus.step_x, bus.step_y, bus.dir); end
    for (int f = 1; f <= 31; f++) begin
      run_frame(16'h001A, ticks, pos);
      model_frame(16'h001A);
      if (f == 30) begin
        checks++; if (bus.step_y !== 10'h3FF) begin errors++; $display("[TB] FAIL midboost_f30 got %0d want -1", $signed(bus.step_y)); end
      end
      if (f == 31) begin
        checks++; if (bus.step_y !== 10'h3FE) begin errors++; $display("[TB] FAIL midboost_f31 got %0d want -2", $signed(bus.step_y)); end
      end
    end
  endtask

  task automatic test_long_high();
    int ticks;
    ticks = 0;
    @(negedge clk);
    bus.keycode   = 16'h0000;
    bus.frame_clk = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      if (bus.frame_tick === 1'b1) ticks++;
    end
    bus.frame_clk = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.frame_tick === 1'b1) ticks++;
    end
    model_frame(16'h0000);
    checks++; if (ticks !== 1) begin errors++; $display("[TB] FAIL long_high_ticks got %0d want 1", ticks); end
    checks++; if (bus.step_y !== 10'(exp_y()) || bus.dir !== 3'(m_dir)) begin errors++; $display("[TB] FAIL long_high_state got y=%0d dir=%0d want y=%0d dir=%0d", $signed(bus.step_y), bus.dir, exp_y(), m_dir); end
  endtask

  function automatic logic [7:0] pick_code();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h1A;
      2:       return 8'h16;
      3:       return 8'h04;
      4:       return 8'h07;
      5:       return 8'h2C;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random();
    int ticks, pos;
    logic [15:0] k;
    k = 16'h0000;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) < 4) k = {pick_code(), pick_code()};
      run_frame(k, ticks, pos);
      model_frame(k);
      checks++;
      if (ticks !== 1 || pos !== 3 || bus.step_x !== 10'(exp_x()) || bus.step_y !== 10'(exp_y()) || bus.dir !== 3'(m_dir)) begin
        errors++;
        $display("[TB] FAIL random_frame%0d key=%h got x=%0d y=%0d dir=%0d tick=%0d@%0d want x=%0d y=%0d dir=%0d tick=1@3",
                 f, k, $signed(bus.step_x), $signed(bus.step_y), bus.dir, ticks, pos, exp_x(), exp_y(), m_dir);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.keycode = {pick_code(), pick_code()};
        repeat (2) @(negedge clk);
      end
    end
  endtask

  initial begin
    bus.keycode   = 16'h0000;
    bus.frame_clk = 1'b0;
    test_reset();
    test_single_frame();
    test_boost();
    test_priority();
    test_transient_key();
    test_reset_mid_boost();
    test_long_high();
    test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
